trig_cos32: RTL and testbench

- Pipelined fixed-point cosine unit: 32-bit phase angle in, signed 64-bit Q32.32 cosine out.
- Piecewise-linear approximation over one quadrant; the other three quadrants are derived by folding the angle and negating the result.
- Sits in the math datapath wherever real-valued cosine is needed; one result per clock.

---
 rtl/trig_pkg.sv | 41 ++++
 rtl/trig_pwl_seg.sv | 42 ++++
 rtl/trig_cos32.sv | 81 ++++++++
 tb/tb_trig_cos32.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared constants for the piecewise-linear cosine unit: quadrant layout,
// Q32.32 unity and the quarter-wave node table.
package trig_pkg;

  localparam int unsigned COS_LATENCY  = 3;
  localparam int unsigned SEG_BITS_DEF = 4;
  localparam int unsigned QUAD_MSB     = 31;
  localparam int unsigned QUAD_LSB     = 30;
  localparam int unsigned PHASE_BITS   = 30;

  localparam logic [32:0] Q32_ONE = 33'h1_0000_0000;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  // round(cos(k*pi/32) * 2^32), k = 0..16
  localparam logic [32:0] NODE_C [17] = '{
    Q32_ONE,
    33'd4274285855,
    33'd4212440704,
    33'd4110027446,
    33'd3968032378,
    33'd3787822988,
    33'd3571134792,
    33'd3320054617,
    33'd3037000500,
    33'd2724698408,
    33'd2386155981,
    33'd2024633568,
    33'd1643612827,
    33'd1246763195,
    33'd837906553,
    33'd420980412,
    33'd0
  };

endpackage

// File: rtl/trig_pwl_seg.sv
// Quarter-wave chord evaluator: looks up the segment nodes, registers the
// delta*frac product, and presents f = C[k] - (D[k]*frac >> FRAC_W).
module trig_pwl_seg
  import trig_pkg::*;
#(
  parameter int unsigned SEG_BITS = SEG_BITS_DEF
) (
  input  logic                           clk,
  input  logic [SEG_BITS-1:0]            k,
  input  logic [PHASE_BITS-SEG_BITS-1:0] frac,
  output logic [32:0]                    f
);

  localparam int unsigned FRAC_W  = PHASE_BITS - SEG_BITS;
  localparam int unsigned DELTA_W = 30;
  localparam int unsigned PROD_W  = DELTA_W + FRAC_W;
  localparam logic [SEG_BITS:0] IDX_ONE = 1;

  logic [SEG_BITS:0]   idx_lo;
  logic [SEG_BITS:0]   idx_hi;
  logic [32:0]         c_lo;
  logic [32:0]         c_hi;
  logic [DELTA_W-1:0]  delta;
  logic [32:0]         node_q;
  logic [PROD_W-1:0]   prod_q;

  always_comb begin
    idx_lo = {1'b0, k};
    idx_hi = idx_lo + IDX_ONE;
    c_lo   = NODE_C[idx_lo];
    c_hi   = NODE_C[idx_hi];
    delta  = DELTA_W'(c_lo - c_hi);
  end

  always_ff @(posedge clk) begin
    node_q <= c_lo;
    prod_q <= PROD_W'(delta) * PROD_W'(frac);
  end

  assign f = node_q - 33'(prod_q >> FRAC_W);

endmodule

// File: rtl/trig_cos32.sv
// Three-stage fixed-point cosine: folds the phase into one quadrant, evaluates
// the chord approximation, and restores the sign in Q32.32.
module trig_cos32
  import trig_pkg::*;
#(
  parameter int unsigned SEG_BITS = SEG_BITS_DEF,
  parameter int unsigned LATENCY  = COS_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] angle,
  output logic        out_valid,
  output logic [63:0] cos_out
);

  localparam int unsigned FRAC_W = PHASE_BITS - SEG_BITS;
  localparam logic [PHASE_BITS:0] QUARTER = {1'b1, {PHASE_BITS{1'b0}}};

  quad_t                 quad;
  logic [PHASE_BITS-1:0] r;
  logic [PHASE_BITS:0]   x;
  logic                  mirror;
  logic                  negate;

  logic [SEG_BITS-1:0]   s1_k;
  logic [FRAC_W-1:0]     s1_frac;
  logic                  s1_zero;
  logic                  s1_neg;
  logic                  s2_zero;
  logic                  s2_neg;
  logic [LATENCY-1:0]    vld;
  logic [32:0]           f;
  logic [63:0]           mag;

  always_comb begin
    quad   = quad_t'(angle[QUAD_MSB:QUAD_LSB]);
    r      = angle[PHASE_BITS-1:0];
    mirror = (quad == QUAD_1) || (quad == QUAD_3);
    negate = (quad == QUAD_1) || (quad == QUAD_2);
    x      = mirror ? (QUARTER - {1'b0, r}) : {1'b0, r};
  end

  // x == 2^30 lands on the zero crossing, which has no valid segment index
  always_ff @(posedge clk) begin
    s1_k    <= x[PHASE_BITS-1:FRAC_W];
    s1_frac <= x[FRAC_W-1:0];
    s1_zero <= x[PHASE_BITS];
    s1_neg  <= negate;
    s2_zero <= s1_zero;
    s2_neg  <= s1_neg;
  end

  trig_pwl_seg #(
    .SEG_BITS (SEG_BITS)
  ) u_seg (
    .clk  (clk),
    .k    (s1_k),
    .frac (s1_frac),
    .f    (f)
  );

  always_comb begin
    mag = s2_zero ? '0 : {{(64-33){1'b0}}, f};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= '0;
      cos_out <= '0;
    end else begin
      vld <= {vld[LATENCY-2:0], in_valid};
      if (vld[LATENCY-2]) begin
        cos_out <= s2_neg ? -mag : mag;
      end
    end
  end

  assign out_valid = vld[LATENCY-1];

endmodule

// File: tb/tb_trig_cos32.sv
// Directed and sweep checks for trig_cos32 against hand-computed nodes and
// a real-valued cosine reference.
module tb_trig_cos32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] angle;
  logic        out_valid;
  logic [63:0] cos_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [63:0] ONE     = 64'h0000_0001_0000_0000;
  localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_0000_0000;
  localparam real         TOL     = 1.3e-3;
  localparam real         PI      = 3.14159265358979323846;

  localparam logic [32:0] C_REF [17] = '{
    33'd4294967296, 33'd4274285855, 33'd4212440704, 33'd4110027446,
    33'd3968032378, 33'd3787822988, 33'd3571134792, 33'd3320054617,
    33'd3037000500, 33'd2724698408, 33'd2386155981, 33'd2024633568,
    33'd1643612827, 33'd1246763195, 33'd837906553,  33'd420980412,
    33'd0
  };

  trig_cos32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .angle     (angle),
    .out_valid (out_valid),
    .cos_out   (cos_out)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic real to_real(logic [63:0] v);
    return real'($signed(v)) / 4294967296.0;
  endfunction

  function automatic real ref_cos(logic [31:0] a);
    return $cos(real'(a) * 2.0 * PI / 4294967296.0);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; angle = 32'h0;
    step(); step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (cos_out !== 64'h0) $display("FAIL reset_data: got %h expected %h", cos_out, 64'h0);
    else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
    step(); step(); step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_no_spurious: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_axes();
    logic [31:0] vec [4];
    logic [63:0] exp_v [4];
    vec   = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    exp_v = '{ONE, 64'h0, NEG_ONE, 64'h0};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin in_valid = 1'b1; angle = vec[i]; end
      else in_valid = 1'b0;
      step();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || cos_out !== exp_v[i-2])
          $display("FAIL axes[%0d]: got valid=%b %h expected valid=1 %h", i-2, out_valid, cos_out, exp_v[i-2]);
        else n_pass++;
      end
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL axes_idle: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_near_wrap();
    real got;
    in_valid = 1'b1; angle = 32'hFFFF_FFFC;
    step();
    in_valid = 1'b0;
    step(); step();
    got = to_real(cos_out);
    n_checks++;
    if (out_valid !== 1'b1 || cos_out !== 64'h0000_0000_FFFF_FFFF)
      $display("FAIL near_wrap_exact: got valid=%b %h expected valid=1 %h", out_valid, cos_out, 64'h0000_0000_FFFF_FFFF);
    else n_pass++;
    n_checks++;
    if (got > 1.0 || got < 1.0 - 1e-6)
      $display("FAIL near_wrap_range: got %f expected within 1e-6 below 1.0", got);
    else n_pass++;
  endtask

  task automatic test_sixty();
    real got;
    real want [2];
    logic [31:0] vec [2];
    vec  = '{32'h2AAA_AAAB, 32'h5555_5555};
    want = '{0.5, -0.5};
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin in_valid = 1'b1; angle = vec[i]; end
      else in_valid = 1'b0;
      step();
      if (i >= 2) begin
        got = to_real(cos_out);
        n_checks++;
        if (out_valid !== 1'b1 || got - want[i-2] > TOL || want[i-2] - got > TOL)
          $display("FAIL sixty[%0d]: got valid=%b %f expected valid=1 %f", i-2, out_valid, got, want[i-2]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_nodes();
    logic [31:0] vec [32];
    logic [63:0] exp_v [32];
    logic [63:0] prev;
    prev = 64'h0;
    for (int j = 0; j < 16; j++) begin
      vec[j]      = 32'(j) << 26;
      exp_v[j]    = {31'b0, C_REF[j]};
      vec[j+16]   = 32'h4000_0000 + (32'(j) << 26);
      exp_v[j+16] = (j == 0) ? 64'h0 : -{31'b0, C_REF[16-j]};
    end
    for (int i = 0; i < 34; i++) begin
      if (i < 32) begin in_valid = 1'b1; angle = vec[i]; end
      else in_valid = 1'b0;
      step();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || cos_out !== exp_v[i-2])
          $display("FAIL node[%0d]: got valid=%b %h expected valid=1 %h", i-2, out_valid, cos_out, exp_v[i-2]);
        else n_pass++;
        if (i - 2 >= 1 && i - 2 < 16) begin
          n_checks++;
          if (!($signed(cos_out) < $signed(prev)))
            $display("FAIL node_monotonic[%0d]: got %h expected below %h", i-2, cos_out, prev);
          else n_pass++;
        end
        prev = cos_out;
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] q [$];
    real got;
    real want;
    int n;
    for (int i = 0; i < 4096; i++) q.push_back(32'(i) << 20);
    for (int i = 0; i < 10000; i++) q.push_back($urandom);
    n = q.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin in_valid = 1'b1; angle = q[i]; end
      else in_valid = 1'b0;
      step();
      if (i >= 2) begin
        got  = to_real(cos_out);
        want = ref_cos(q[i-2]);
        n_checks++;
        if (out_valid !== 1'b1 || got - want > TOL || want - got > TOL)
          $display("FAIL sweep angle=%h: got valid=%b %f expected valid=1 %f", q[i-2], out_valid, got, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; angle = 32'h0000_0000;
    step();
    angle = 32'h8000_0000;
    step();
    rst = 1'b1; angle = 32'h2000_0000;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || cos_out !== 64'h0)
      $display("FAIL midreset_clear: got valid=%b %h expected valid=0 %h", out_valid, cos_out, 64'h0);
    else n_pass++;
    rst = 1'b0; angle = 32'h4000_0000;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midreset_stale1: got %b expected 0", out_valid);
    else n_pass++;
    angle = 32'h8000_0000;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midreset_stale2: got %b expected 0", out_valid);
    else n_pass++;
    angle = 32'h0000_0000;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || cos_out !== 64'h0)
      $display("FAIL midreset_out0: got valid=%b %h expected valid=1 %h", out_valid, cos_out, 64'h0);
    else n_pass++;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || cos_out !== NEG_ONE)
      $display("FAIL midreset_out1: got valid=%b %h expected valid=1 %h", out_valid, cos_out, NEG_ONE);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || cos_out !== ONE)
      $display("FAIL midreset_out2: got valid=%b %h expected valid=1 %h", out_valid, cos_out, ONE);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || cos_out !== ONE)
      $display("FAIL midreset_hold: got valid=%b %h expected valid=0 %h", out_valid, cos_out, ONE);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; angle = 32'h0;
    test_reset();
    test_axes();
    test_near_wrap();
    test_sixty();
    test_nodes();
    test_sweep();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
